// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan decoder: samples the multiplexed anode/segment buses and
// rebuilds each digit's hex value once the display has dwelled long enough.
module ssd_scan_decoder #(
   parameter int N_DIGITS      = 8,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [N_DIGITS-1:0]   i_an,
   input  logic [6:0]            i_seg,
   output logic [4*N_DIGITS-1:0] o_digits,
   output logic [N_DIGITS-1:0]   o_digit_valid,
   output logic [N_DIGITS-1:0]   o_seg_err,
   output logic                  o_frame_done,
   output logic                  o_an_err
);
   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD, ST_MULTI} state_t;

   logic [N_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
   logic [6:0]            r_seg_s1, r_seg_s2, r_seg_prev;
   logic [CW-1:0]         r_cnt;
   state_t                r_state, w_state_nxt;
   logic [N_DIGITS-1:0]   r_mask;
   logic [4*N_DIGITS-1:0] r_digits;
   logic [N_DIGITS-1:0]   r_valid, r_err;
   logic                  r_frame_done, r_an_err;

   logic [N_DIGITS-1:0]   w_inv;
   logic                  w_none, w_multi, w_one, w_changed;
   logic                  w_capture, w_an_err_set;
   logic [4:0]            w_dec;

   function automatic logic [4:0] f_decode(input logic [6:0] s);
      case (s)
         7'h40: f_decode = 5'h10;  7'h79: f_decode = 5'h11;
         7'h24: f_decode = 5'h12;  7'h30: f_decode = 5'h13;
         7'h19: f_decode = 5'h14;  7'h12: f_decode = 5'h15;
         7'h02: f_decode = 5'h16;  7'h78: f_decode = 5'h17;
         7'h00: f_decode = 5'h18;  7'h10: f_decode = 5'h19;
         7'h08: f_decode = 5'h1A;  7'h03: f_decode = 5'h1B;
         7'h46: f_decode = 5'h1C;  7'h21: f_decode = 5'h1D;
         7'h06: f_decode = 5'h1E;  7'h0E: f_decode = 5'h1F;
         default: f_decode = 5'h00;
      endcase
   endfunction

   // Synchronizers reset to the bus idle level so reset never looks like MULTI.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_an_s1    <= '1;
         r_an_s2    <= '1;
         r_an_prev  <= '1;
         r_seg_s1   <= '1;
         r_seg_s2   <= '1;
         r_seg_prev <= '1;
         r_cnt      <= '0;
      end else begin
         r_an_s1    <= i_an;
         r_an_s2    <= r_an_s1;
         r_an_prev  <= r_an_s2;
         r_seg_s1   <= i_seg;
         r_seg_s2   <= r_seg_s1;
         r_seg_prev <= r_seg_s2;
         if (w_changed)           r_cnt <= '0;
         else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
      end
   end

   assign w_inv     = ~r_an_s2;
   assign w_none    = (w_inv == '0);
   assign w_multi   = !w_none && ((w_inv & (w_inv - N_DIGITS'(1))) != '0);
   assign w_one     = !w_none && !w_multi;
   assign w_changed = ({r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev});
   assign w_dec     = f_decode(r_seg_s2);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_none)         w_state_nxt = ST_IDLE;
      else if (w_multi)   w_state_nxt = ST_MULTI;
      else if (w_changed) w_state_nxt = ST_SETTLE;
      else begin
         case (r_state)
            ST_IDLE, ST_MULTI: w_state_nxt = ST_SETTLE;
            ST_SETTLE:         if (r_cnt == CNT_MAX) w_state_nxt = ST_HOLD;
            default:           w_state_nxt = r_state;
         endcase
      end
   end

   // HOLD is the "already captured" marker: one capture per stable dwell.
   always_comb begin
      w_capture    = (r_state == ST_SETTLE) && w_one && !w_changed && (r_cnt == CNT_MAX);
      w_an_err_set = w_multi && (r_state != ST_MULTI);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_mask       <= '0;
         r_digits     <= '0;
         r_valid      <= '0;
         r_err        <= '0;
         r_frame_done <= 1'b0;
         r_an_err     <= 1'b0;
      end else begin
         r_frame_done <= &r_mask;
         r_an_err     <= w_an_err_set;
         r_mask       <= ((&r_mask) ? '0 : r_mask) | (w_capture ? w_inv : '0);
         if (w_capture) begin
            for (int i = 0; i < N_DIGITS; i++) begin
               if (w_inv[i]) begin
                  if (w_dec[4]) begin
                     r_digits[4*i +: 4] <= w_dec[3:0];
                     r_valid[i]         <= 1'b1;
                     r_err[i]           <= 1'b0;
                  end else begin
                     r_err[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign o_digits      = r_digits;
   assign o_digit_valid = r_valid;
   assign o_seg_err     = r_err;
   assign o_frame_done  = r_frame_done;
   assign o_an_err      = r_an_err;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed vector table, hand sequences and a
// randomized run, all checked every cycle against a pin-history reference model.
module tb_ssd_scan_decoder;
   localparam int N = 8;
   localparam int S = 16;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic [7:0]  i_an = 8'hFF;
   logic [6:0]  i_seg = 7'h7F;
   logic [31:0] o_digits;
   logic [7:0]  o_digit_valid, o_seg_err;
   logic        o_frame_done, o_an_err;

   ssd_scan_decoder #(.N_DIGITS(N), .SETTLE_CYCLES(S)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_an(i_an), .i_seg(i_seg),
      .o_digits(o_digits), .o_digit_valid(o_digit_valid), .o_seg_err(o_seg_err),
      .o_frame_done(o_frame_done), .o_an_err(o_an_err));

   always #5 i_clk = ~i_clk;

   int checks = 0, failures = 0;
   int fd_cnt = 0, ae_cnt = 0;

   logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct packed { logic [7:0] an; logic [6:0] seg; } pin_t;
   pin_t        hist[$];
   logic [31:0] m_dig;
   logic [7:0]  m_vld, m_err, m_mask;
   logic        m_fd, m_ae;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int zeros(input logic [7:0] a);
      return $countones(~a);
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back({8'hFF, 7'h7F});
      m_dig = '0; m_vld = '0; m_err = '0; m_mask = '0; m_fd = 1'b0; m_ae = 1'b0;
   endtask

   // A capture happens when the pin value seen two edges ago closes a run of
   // exactly S+1 identical samples on a single-selected anode.
   task automatic model_edge();
      pin_t x, p;
      int n, run, idx, val;
      logic full;
      hist.push_back({i_an, i_seg});
      if (hist.size() > S + 8) void'(hist.pop_front());
      n = hist.size();
      x = hist[n-3];
      p = hist[n-4];
      run = 1;
      for (int k = n - 4; k >= 0 && run < S + 2; k--) begin
         if (hist[k] != x) break;
         run++;
      end
      full = (m_mask == 8'hFF);
      m_fd = full;
      m_ae = (zeros(x.an) >= 2) && (zeros(p.an) < 2);
      if (full) m_mask = '0;
      if (run == S + 1 && zeros(x.an) == 1) begin
         idx = 0;
         for (int k = 0; k < 8; k++) if (!x.an[k]) idx = k;
         val = -1;
         for (int k = 0; k < 16; k++) if (lut[k] == x.seg) val = k;
         if (val >= 0) begin
            m_dig[4*idx +: 4] = 4'(val);
            m_vld[idx] = 1'b1;
            m_err[idx] = 1'b0;
         end else begin
            m_err[idx] = 1'b1;
         end
         m_mask[idx] = 1'b1;
      end
   endtask

   task automatic run(input logic [7:0] an, input logic [6:0] seg, input int cyc);
      i_an = an;
      i_seg = seg;
      for (int c = 0; c < cyc; c++) begin
         @(posedge i_clk);
         model_edge();
         #1;
         chk("digits", o_digits, m_dig);
         chk("digit_valid", {24'h0, o_digit_valid}, {24'h0, m_vld});
         chk("seg_err", {24'h0, o_seg_err}, {24'h0, m_err});
         chk("frame_done", {31'h0, o_frame_done}, {31'h0, m_fd});
         chk("an_err", {31'h0, o_an_err}, {31'h0, m_ae});
         if (o_frame_done) fd_cnt++;
         if (o_an_err) ae_cnt++;
      end
   endtask

   task automatic chk_state(input string nm, input logic [31:0] dig, input logic [7:0] vld,
                            input logic [7:0] err);
      chk({nm, "_digits"}, o_digits, dig);
      chk({nm, "_valid"}, {24'h0, o_digit_valid}, {24'h0, vld});
      chk({nm, "_err"}, {24'h0, o_seg_err}, {24'h0, err});
   endtask

   typedef struct {
      logic [7:0] an; logic [6:0] seg; int cyc;
      logic [31:0] dig; logic [7:0] vld; logic [7:0] err;
   } vec_t;
   vec_t tbl [12];

   initial begin
      tbl[0]  = '{8'hFE, 7'h40, 30, 32'h00000000, 8'h01, 8'h00};
      tbl[1]  = '{8'hFE, 7'h79, 20, 32'h00000001, 8'h01, 8'h00};
      tbl[2]  = '{8'hFD, 7'h24, 20, 32'h00000021, 8'h03, 8'h00};
      tbl[3]  = '{8'hFB, 7'h30, 20, 32'h00000321, 8'h07, 8'h00};
      tbl[4]  = '{8'hF7, 7'h19, 20, 32'h00004321, 8'h0F, 8'h00};
      tbl[5]  = '{8'hEF, 7'h12, 20, 32'h00054321, 8'h1F, 8'h00};
      tbl[6]  = '{8'hDF, 7'h02, 20, 32'h00654321, 8'h3F, 8'h00};
      tbl[7]  = '{8'hBF, 7'h78, 20, 32'h07654321, 8'h7F, 8'h00};
      tbl[8]  = '{8'h7F, 7'h00, 20, 32'h87654321, 8'hFF, 8'h00};
      tbl[9]  = '{8'hFD, 7'h12, 20, 32'h87654351, 8'hFF, 8'h00};
      tbl[10] = '{8'hFD, 7'h7F, 20, 32'h87654351, 8'hFF, 8'h02};
      tbl[11] = '{8'hFD, 7'h0E, 20, 32'h876543F1, 8'hFF, 8'h00};

      model_reset();
      #12;
      chk_state("reset", 32'h0, 8'h00, 8'h00);
      chk("reset_fd", {31'h0, o_frame_done}, 32'h0);
      chk("reset_aerr", {31'h0, o_an_err}, 32'h0);
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;

      // Plan 1-3: scan, frame completion, blank pattern, recovery.
      for (int v = 0; v < 12; v++) begin
         run(tbl[v].an, tbl[v].seg, tbl[v].cyc);
         chk_state($sformatf("vec%0d", v), tbl[v].dig, tbl[v].vld, tbl[v].err);
         if (v == 0) chk("first_no_frame", fd_cnt, 0);
         if (v == 8) chk("frame_once", fd_cnt, 1);
      end
      chk("table_frame_total", fd_cnt, 1);

      // Plan 4: multi-anode condition.
      ae_cnt = 0;
      run(8'hFC, 7'h08, 40);
      chk("multi_aerr_once", ae_cnt, 1);
      chk_state("multi", 32'h876543F1, 8'hFF, 8'h00);
      run(8'hFE, 7'h08, 20);
      chk_state("after_multi", 32'h876543FA, 8'hFF, 8'h00);

      // Plan 5: short dwell is ignored, full dwell captures.
      run(8'hFB, 7'h21, 10);
      run(8'hFF, 7'h21, 5);
      chk_state("glitch", 32'h876543FA, 8'hFF, 8'h00);
      run(8'hFB, 7'h21, 20);
      chk_state("dwell", 32'h87654DFA, 8'hFF, 8'h00);

      // Plan 6: second full frame, then reset in the middle of a settle window.
      fd_cnt = 0;
      for (int d = 0; d < 8; d++) run(~(8'h01 << d), lut[d + 8], 20);
      chk("frame2", fd_cnt, 1);
      run(8'hFE, 7'h40, 8);
      i_rstn = 1'b0;
      #1;
      model_reset();
      chk_state("midreset", 32'h0, 8'h00, 8'h00);
      chk("midreset_fd", {31'h0, o_frame_done}, 32'h0);
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      fd_cnt = 0;
      for (int d = 0; d < 7; d++) run(~(8'h01 << d), lut[d], 20);
      chk("partial_frame", fd_cnt, 0);
      run(8'h7F, lut[7], 20);
      chk("frame_after_reset", fd_cnt, 1);

      // Randomized dwell sequence against the model.
      for (int r = 0; r < 80; r++) begin
         int kind, a, b;
         logic [7:0] an;
         logic [6:0] seg;
         kind = $urandom_range(0, 9);
         a = $urandom_range(0, 7);
         b = (a + 1 + $urandom_range(0, 6)) % 8;
         if (kind <= 6)      an = ~(8'h01 << a);
         else if (kind == 7) an = 8'hFF;
         else                an = ~(8'h01 << a) & ~(8'h01 << b);
         if ($urandom_range(0, 3) != 0) seg = lut[$urandom_range(0, 15)];
         else                            seg = 7'($urandom);
         run(an, seg, $urandom_range(1, 40));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
